dmem_responder: RTL

Data-memory responder for the 5-stage pipeline's load/store bus: the memory end of the `daddr`/`dreq`/`dwrite`/`dsize`/`dbusy`/`dready_n` interface driven by the MEM stage.

- Latches one request at a time and stalls the pipeline with `dbusy` for a programmable number of wait states.
- Performs byte/halfword/word accesses on an internal word array.
- Completes each transaction with a one-cycle active-low `dready_n` pulse carrying right-aligned read data.

---
 rtl/dmem_responder_pkg.sv | 36 +++
 rtl/dmem_lane_align.sv | 45 ++++
 rtl/dmem_responder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_responder_pkg;

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    DSIZE_BYTE = 2'b00,
    DSIZE_HALF = 2'b01,
    DSIZE_WORD = 2'b10,
    DSIZE_RSVD = 2'b11
  } dsize_e;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'b00,
    DMEM_WAIT = 2'b01,
    DMEM_RESP = 2'b10
  } dmem_state_e;

  // Latched request payload; the byte address is kept separately because its width is a parameter.
  typedef struct packed {
    dsize_e              size;
    logic                write;
    logic [DATA_W-1:0]   wdata;
  } dmem_req_t;

  function automatic logic is_misaligned(dsize_e size, logic [1:0] lane);
    case (size)
      DSIZE_BYTE: return 1'b0;
      DSIZE_HALF: return lane[0];
      DSIZE_WORD: return lane != 2'b00;
      default:    return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: write enables and positioned store word, right-aligned zero-filled load data.
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata,
  output logic        misalign
);

  dsize_e size_e;
  assign size_e = dsize_e'(size);

  always_comb begin
    be       = 4'b0000;
    wword    = '0;
    rdata    = '0;
    misalign = is_misaligned(size_e, lane);
    if (!misalign) begin
      unique case (size_e)
        DSIZE_BYTE: begin
          be    = 4'b0001 << lane;
          wword = {4{wdata[7:0]}};
          rdata = {24'h000000, rword[{lane, 3'b000} +: 8]};
        end
        DSIZE_HALF: begin
          be    = lane[1] ? 4'b1100 : 4'b0011;
          wword = {2{wdata[15:0]}};
          rdata = {16'h0000, (lane[1] ? rword[31:16] : rword[15:0])};
        end
        DSIZE_WORD: begin
          be    = 4'b1111;
          wword = wdata;
          rdata = rword;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory end of the MEM-stage load/store bus: one request at a time, programmable wait
// states, single-cycle active-low completion strobe.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 14,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] daddr,
  input  logic        dreq,
  input  logic        dwrite,
  input  logic [1:0]  dsize,
  input  logic [31:0] input_ddata,
  output logic [31:0] output_ddata,
  output logic        dbusy,
  output logic        dready_n,
  output logic        dmisalign
);

  localparam int unsigned BA_W  = ADDR_WIDTH + 2;
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  dmem_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BA_W-1:0]   addr_q, acc_addr;
  dmem_req_t         req_q, req_d, live_req, acc_req;
  logic [31:0]       out_d;
  logic              dready_n_d, dmisalign_d, commit, mem_we;
  logic [3:0]        be;
  logic [31:0]       wword, rdata, rword;
  logic              misalign;
  logic [ADDR_WIDTH-1:0] widx;
  logic [31:0]       mem [0:DEPTH-1];
  logic              addr_unused;

  // Address bits above the array wrap away.
  assign addr_unused = ^daddr[31:BA_W];

  // Store data is ignored (and may float) on loads.
  always_comb begin
    live_req.size  = dsize_e'(dsize);
    live_req.write = dwrite;
    live_req.wdata = dwrite ? input_ddata : '0;
  end

  // With zero wait states the access happens on the acceptance edge, so use the live request.
  assign acc_req  = (state_q == DMEM_IDLE) ? live_req : req_q;
  assign acc_addr = (state_q == DMEM_IDLE) ? daddr[BA_W-1:0] : addr_q;
  assign widx     = acc_addr[BA_W-1:2];
  assign rword    = mem[widx];

  dmem_lane_align u_align (
    .lane     (acc_addr[1:0]),
    .size     (acc_req.size),
    .wdata    (acc_req.wdata),
    .rword    (rword),
    .be       (be),
    .wword    (wword),
    .rdata    (rdata),
    .misalign (misalign)
  );

  assign dbusy = rst & dreq & (state_q != DMEM_RESP);

  // Next state, wait counter, request latch and response outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    out_d       = output_ddata;
    dready_n_d  = 1'b1;
    dmisalign_d = 1'b0;
    commit      = 1'b0;
    case (state_q)
      DMEM_IDLE: begin
        if (dreq) begin
          req_d   = live_req;
          cnt_d   = CNT_LOAD;
          state_d = (WAIT_CYCLES > 0) ? DMEM_WAIT : DMEM_RESP;
        end
      end
      DMEM_WAIT: begin
        if (!dreq)                  state_d = DMEM_IDLE;
        else if (cnt_q == '0)       state_d = DMEM_RESP;
        else                        cnt_d   = cnt_q - CNT_W'(1);
      end
      DMEM_RESP: state_d = DMEM_IDLE;
      default:   state_d = DMEM_IDLE;
    endcase
    if (state_d == DMEM_RESP) begin
      commit      = 1'b1;
      dready_n_d  = 1'b0;
      dmisalign_d = misalign;
      if (!acc_req.write) out_d = rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= DMEM_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      req_q        <= '0;
      output_ddata <= '0;
      dready_n     <= 1'b1;
      dmisalign    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_q        <= req_d;
      output_ddata <= out_d;
      dready_n     <= dready_n_d;
      dmisalign    <= dmisalign_d;
      if (state_q == DMEM_IDLE && dreq) addr_q <= daddr[BA_W-1:0];
    end
  end

  assign mem_we = rst & commit & acc_req.write;

  // Array is deliberately not reset; lane enables are already zero on misaligned access.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= wword[8*b +: 8];
      end
    end
  end

endmodule
